// File: rtl/data_cache_line_sequencer.sv
// Line-level refill/writeback sequencer between the data cache controller and the banked cache block.
// Writeback support is compiled in only when DCACHE_WRITEBACK_EN is defined; otherwise the block is refill-only.
module data_cache_line_sequencer #(
    parameter int  CACHE_CHIP  = 4,
    parameter int  INDEX_WIDTH = 7,
    parameter int  PORT_WIDTH  = 32,
    localparam int CHIP_ADDR   = $clog2(CACHE_CHIP)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   refill_req_i,
    input  logic                   writeback_req_i,
    input  logic [INDEX_WIDTH-1:0] index_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic [PORT_WIDTH-1:0]  mem_data_i,
    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    output logic [PORT_WIDTH-1:0]  wb_data_o,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic                   port0_write_o,
    output logic [CHIP_ADDR-1:0]   port0_bank_select_o,
    output logic [INDEX_WIDTH-1:0] port0_address_o,
    output logic [3:0]             port0_byte_write_o,
    output logic [PORT_WIDTH-1:0]  port0_data_o,
    output logic                   port1_read_o,
    output logic [CHIP_ADDR-1:0]   port1_bank_select_o,
    output logic [INDEX_WIDTH-1:0] port1_address_o,
    input  logic [PORT_WIDTH-1:0]  port1_data_i
);

`ifdef DCACHE_WRITEBACK_EN
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REFILL   = 3'd1,
        WB_READ  = 3'd2,
        WB_LATCH = 3'd3,
        WB_SEND  = 3'd4,
        DONE     = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REFILL   = 3'd1,
        DONE     = 3'd5
    } state_t;
`endif

    localparam logic [CHIP_ADDR-1:0] CNT_LAST = CHIP_ADDR'(CACHE_CHIP - 1);

    state_t                 state;
    logic [CHIP_ADDR-1:0]   cnt;
    logic [INDEX_WIDTH-1:0] index_q;
    logic                   cnt_last;

`ifdef DCACHE_WRITEBACK_EN
    logic                   pend_refill;
    logic [PORT_WIDTH-1:0]  wb_q;
`else
    logic                   unused_wb_inputs;
    assign unused_wb_inputs = ^{writeback_req_i, wb_ready_i, port1_data_i};
`endif

    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            cnt         <= '0;
            index_q     <= '0;
`ifdef DCACHE_WRITEBACK_EN
            pend_refill <= 1'b0;
            wb_q        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef DCACHE_WRITEBACK_EN
                    if (writeback_req_i) begin
                        index_q     <= index_i;
                        pend_refill <= refill_req_i;
                        cnt         <= '0;
                        state       <= WB_READ;
                    end else
`endif
                    if (refill_req_i) begin
                        index_q <= index_i;
                        cnt     <= '0;
                        state   <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_valid_i) begin
                        if (cnt_last) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`ifdef DCACHE_WRITEBACK_EN
                WB_READ: begin
                    state <= WB_LATCH;
                end
                WB_LATCH: begin
                    wb_q  <= port1_data_i;
                    state <= WB_SEND;
                end
                WB_SEND: begin
                    if (wb_ready_i) begin
                        if (cnt_last) begin
                            // A queued refill reuses the latched index and takes over the line.
                            if (pend_refill) begin
                                pend_refill <= 1'b0;
                                cnt         <= '0;
                                state       <= REFILL;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= WB_READ;
                        end
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign mem_ready_o = (state == REFILL);

    // Refill data is a combinational pass-through, gated so idle outputs stay at zero.
    assign port0_write_o       = (state == REFILL) && mem_valid_i;
    assign port0_bank_select_o = cnt;
    assign port0_address_o     = index_q;
    assign port0_byte_write_o  = {4{port0_write_o}};
    assign port0_data_o        = port0_write_o ? mem_data_i : '0;

    assign port1_bank_select_o = cnt;
    assign port1_address_o     = index_q;

`ifdef DCACHE_WRITEBACK_EN
    assign port1_read_o = (state == WB_READ);
    assign wb_valid_o   = (state == WB_SEND);
    assign wb_data_o    = wb_q;
`else
    assign port1_read_o = 1'b0;
    assign wb_valid_o   = 1'b0;
    assign wb_data_o    = '0;
`endif

endmodule

// File: tb/tb_data_cache_line_sequencer.sv
// Directed bench for data_cache_line_sequencer; writeback scenarios run only when DCACHE_WRITEBACK_EN is defined.
module tb_data_cache_line_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        refill_req;
    logic        writeback_req;
    logic [6:0]  index;
    logic        busy;
    logic        done;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        wb_ready;
    logic        p0_write;
    logic [1:0]  p0_bank;
    logic [6:0]  p0_addr;
    logic [3:0]  p0_bw;
    logic [31:0] p0_data;
    logic        p1_read;
    logic [1:0]  p1_bank;
    logic [6:0]  p1_addr;
    logic [31:0] p1_data;

    logic [31:0] bank_mem [4];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_cache_line_sequencer #(
        .CACHE_CHIP (4),
        .INDEX_WIDTH(7),
        .PORT_WIDTH (32)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .refill_req_i       (refill_req),
        .writeback_req_i    (writeback_req),
        .index_i            (index),
        .busy_o             (busy),
        .done_o             (done),
        .mem_data_i         (mem_data),
        .mem_valid_i        (mem_valid),
        .mem_ready_o        (mem_ready),
        .wb_data_o          (wb_data),
        .wb_valid_o         (wb_valid),
        .wb_ready_i         (wb_ready),
        .port0_write_o      (p0_write),
        .port0_bank_select_o(p0_bank),
        .port0_address_o    (p0_addr),
        .port0_byte_write_o (p0_bw),
        .port0_data_o       (p0_data),
        .port1_read_o       (p1_read),
        .port1_bank_select_o(p1_bank),
        .port1_address_o    (p1_addr),
        .port1_data_i       (p1_data)
    );

    // Cache block read port model: one cycle read latency.
    always @(posedge clk) begin
        if (p1_read) p1_data <= bank_mem[p1_bank];
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [127:0] got;
        rst_n = 1'b0; refill_req = 1'b0; writeback_req = 1'b0; index = '0;
        mem_data = '0; mem_valid = 1'b0; wb_ready = 1'b0; p1_data = '0;
        repeat (2) @(posedge clk);
        #1;
        got = {busy, done, mem_ready, p0_write, p0_bank, p0_addr, p0_bw, p0_data,
               wb_valid, wb_data, p1_read, p1_bank, p1_addr};
        vectors++;
        if (got !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h exp 0", got);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_refill();
        logic [63:0] got, exp;
        cyc(); refill_req = 1'b1; index = 7'h15;
        cyc(); refill_req = 1'b0; index = '0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_data = 32'hA0 + i;
            refill_req = (i == 1);
            #1;
            got = {p0_write, p0_bank, p0_addr, p0_bw, p0_data, mem_ready, busy, done};
            exp = {1'b1, 2'(i), 7'h15, 4'hF, 32'hA0 + 32'(i), 1'b1, 1'b1, 1'b0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL refill_word%0d got %h exp %h", i, got, exp);
            end
            cyc();
        end
        mem_valid = 1'b0; refill_req = 1'b0; #1;
        vectors++;
        if ({done, busy, p0_write} !== 3'b110) begin
            miscompares++;
            $display("FAIL refill_done got %b exp 110", {done, busy, p0_write});
        end
        cyc(); #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL refill_idle got %b exp 00", {done, busy});
        end
    endtask

    task automatic test_refill_gaps();
        logic [6:0] pat = 7'b1011001;
        logic [1:0] exp_bank = 2'd0;
        logic [35:0] got, exp;
        cyc(); refill_req = 1'b1; index = 7'h2A;
        cyc(); refill_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            mem_valid = pat[k]; mem_data = 32'hC0 + k; #1;
            got = {p0_write, p0_bank, mem_ready, done, p0_data};
            exp = {pat[k], exp_bank, 1'b1, 1'b0, pat[k] ? 32'hC0 + 32'(k) : 32'd0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL gap_slot%0d got %h exp %h", k, got, exp);
            end
            if (pat[k]) exp_bank = exp_bank + 2'd1;
            cyc();
        end
        mem_valid = 1'b0; #1;
        vectors++;
        if ({done, p0_write} !== 2'b10) begin
            miscompares++;
            $display("FAIL gap_done got %b exp 10", {done, p0_write});
        end
        cyc(); #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL gap_idle got %b exp 00", {done, busy});
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got;
        cyc(); refill_req = 1'b1; index = 7'h09;
        cyc(); refill_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_valid = 1'b1; mem_data = 32'hE0 + i; #1;
            vectors++;
            if ({p0_write, p0_bank} !== {1'b1, 2'(i)}) begin
                miscompares++;
                $display("FAIL rmid_word%0d got %b exp %b", i, {p0_write, p0_bank}, {1'b1, 2'(i)});
            end
            cyc();
        end
        mem_data = 32'hE2; rst_n = 1'b0; #1;
        got = {busy, done, mem_ready, p0_write, p0_bank, p0_addr, p0_bw, p0_data,
               wb_valid, wb_data, p1_read, p1_bank, p1_addr};
        vectors++;
        if (got !== 128'd0) begin
            miscompares++;
            $display("FAIL rmid_outputs got %h exp 0", got);
        end
        mem_valid = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc(); #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL rmid_after got %b exp 00", {busy, done});
        end
        refill_req = 1'b1; index = 7'h0A;
        cyc(); refill_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_data = 32'hD0 + i; #1;
            vectors++;
            if ({p0_write, p0_bank, p0_addr, p0_data} !== {1'b1, 2'(i), 7'h0A, 32'hD0 + 32'(i)}) begin
                miscompares++;
                $display("FAIL rmid_new%0d got %h", i, {p0_write, p0_bank, p0_addr, p0_data});
            end
            cyc();
        end
        mem_valid = 1'b0; #1;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_new_done got %b exp 1", done);
        end
        cyc();
    endtask

`ifdef DCACHE_WRITEBACK_EN
    task automatic test_writeback();
        logic [34:0] got, exp;
        bank_mem[0] = 32'h11; bank_mem[1] = 32'h22; bank_mem[2] = 32'h33; bank_mem[3] = 32'h44;
        cyc(); writeback_req = 1'b1; index = 7'h03;
        cyc(); writeback_req = 1'b0;
        for (int w = 0; w < 4; w++) begin
            #1;
            vectors++;
            if ({p1_read, p1_bank, p1_addr, wb_valid, done, busy} !== {1'b1, 2'(w), 7'h03, 1'b0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL wb_read%0d got %h", w, {p1_read, p1_bank, p1_addr, wb_valid, done, busy});
            end
            cyc(); #1;
            vectors++;
            if ({p1_read, wb_valid, done} !== 3'b000) begin
                miscompares++;
                $display("FAIL wb_latch%0d got %b exp 000", w, {p1_read, wb_valid, done});
            end
            cyc();
            for (int s = 0; s < 3; s++) begin
                wb_ready = (s == 2); #1;
                got = {wb_valid, wb_data, done, p1_read};
                exp = {1'b1, bank_mem[w], 1'b0, 1'b0};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL wb_send%0d_%0d got %h exp %h", w, s, got, exp);
                end
                cyc();
            end
            wb_ready = 1'b0;
        end
        #1;
        vectors++;
        if ({done, wb_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL wb_done got %b exp 10", {done, wb_valid});
        end
        cyc(); #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL wb_idle got %b exp 00", {done, busy});
        end
    endtask

    task automatic test_combined();
        bank_mem[0] = 32'h55; bank_mem[1] = 32'h66; bank_mem[2] = 32'h77; bank_mem[3] = 32'h88;
        wb_ready = 1'b1;
        cyc(); writeback_req = 1'b1; refill_req = 1'b1; index = 7'h07;
        cyc(); writeback_req = 1'b0; refill_req = 1'b0;
        for (int w = 0; w < 4; w++) begin
            refill_req = (w == 1); #1;
            vectors++;
            if ({p1_read, p1_bank, p0_write, mem_ready, done} !== {1'b1, 2'(w), 3'b000}) begin
                miscompares++;
                $display("FAIL comb_read%0d got %b", w, {p1_read, p1_bank, p0_write, mem_ready, done});
            end
            cyc(); refill_req = 1'b0;
            cyc(); #1;
            vectors++;
            if ({wb_valid, wb_data, done} !== {1'b1, bank_mem[w], 1'b0}) begin
                miscompares++;
                $display("FAIL comb_send%0d got %h exp %h", w, {wb_valid, wb_data, done}, {1'b1, bank_mem[w], 1'b0});
            end
            cyc();
        end
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_data = 32'hB0 + i; #1;
            vectors++;
            if ({p0_write, p0_bank, p0_addr, p0_data, done} !== {1'b1, 2'(i), 7'h07, 32'hB0 + 32'(i), 1'b0}) begin
                miscompares++;
                $display("FAIL comb_refill%0d got %h", i, {p0_write, p0_bank, p0_addr, p0_data, done});
            end
            cyc();
        end
        mem_valid = 1'b0; #1;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL comb_done got %b exp 1", done);
        end
        cyc(); #1;
        vectors++;
        if ({done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL comb_idle got %b exp 00", {done, busy});
        end
    endtask
`else
    task automatic test_wb_ignored();
        writeback_req = 1'b1; index = 7'h03; wb_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc(); #1;
            vectors++;
            if ({busy, p1_read, wb_valid, done} !== 4'b0000) begin
                miscompares++;
                $display("FAIL wbign_cyc%0d got %b exp 0000", c, {busy, p1_read, wb_valid, done});
            end
        end
        writeback_req = 1'b0; wb_ready = 1'b0;
    endtask

    task automatic test_both_refill_only();
        cyc(); writeback_req = 1'b1; refill_req = 1'b1; index = 7'h11;
        cyc(); writeback_req = 1'b0; refill_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_data = 32'hF0 + i; #1;
            vectors++;
            if ({p0_write, p0_bank, p0_addr, p0_data, p1_read} !== {1'b1, 2'(i), 7'h11, 32'hF0 + 32'(i), 1'b0}) begin
                miscompares++;
                $display("FAIL both_refill%0d got %h", i, {p0_write, p0_bank, p0_addr, p0_data, p1_read});
            end
            cyc();
        end
        mem_valid = 1'b0; #1;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL both_done got %b exp 1", done);
        end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_refill();
        test_refill_gaps();
`ifdef DCACHE_WRITEBACK_EN
        test_writeback();
        test_combined();
`else
        test_wb_ignored();
        test_both_refill_only();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
